// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer sequencer and its counter wrapper.
//   - state encodings IDLE/LOAD/ARM/RUN
//   - default expiry-counter width
//   - latched configuration payload
//   - reload-value rule (direction-dependent complement)
package timer_ctrl_pkg;

  localparam int unsigned TICK_W_DEF = 16;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Configuration captured on an accepted start.
  typedef struct packed {
    logic [DATA_W-1:0] period;
    logic              dir;
    logic              mode;
  } cfg_t;

  // Counting up from ~N or down from N both reach the wrap in N+1 counts.
  function automatic logic [DATA_W-1:0] reload_value(input logic [DATA_W-1:0] period,
                                                     input logic              dir);
    return dir ? ~period : period;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Bus between the timer sequencer (master) and its host/counter side (slave).
//   commands : start, stop, period, dir, mode_auto
//   counter  : Load, PData, s (to counter); cnt, Rc (from counter)
//   status   : tick, done, busy, tick_cnt, remain, state
interface timer_ctrl_if
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_W = TICK_W_DEF
);

  logic              start;
  logic              stop;
  logic [DATA_W-1:0] period;
  logic              dir;
  logic              mode_auto;

  logic              Load;
  logic [DATA_W-1:0] PData;
  logic              s;
  logic [DATA_W-1:0] cnt;
  logic              Rc;

  logic              tick;
  logic              done;
  logic              busy;
  logic [TICK_W-1:0] tick_cnt;
  logic [DATA_W-1:0] remain;
  logic [1:0]        state;

  modport master (
    input  start, stop, period, dir, mode_auto, cnt, Rc,
    output Load, PData, s, tick, done, busy, tick_cnt, remain, state
  );

  modport slave (
    output start, stop, period, dir, mode_auto, cnt, Rc,
    input  Load, PData, s, tick, done, busy, tick_cnt, remain, state
  );

endinterface

// File: rtl/timer_ctrl_sat_counter.sv
// Saturating up-counter: clr has priority over inc, holds at all-ones.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear to zero
//   inc      : increment by one unless saturated
//   o_cnt    : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register; never wraps past all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer sequencer driving an external 32-bit loadable up/down counter.
// Produces one-shot or auto-reload expiry ticks and masks the counter's stale
// Rc after every load by passing through ARM before watching it.
//   clk, rst : clock, async active-high reset
//   bus      : timer_ctrl_if master (commands, counter controls, status)
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_W = TICK_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.master bus
);

  state_e            r_state;
  cfg_t              r_cfg;
  logic              r_tick;
  logic              r_done;
  logic [DATA_W-1:0] w_reload;
  logic              w_expire;
  logic              w_clr;
  logic              w_inc;
  logic [TICK_W-1:0] w_tick_cnt;

  assign w_reload = reload_value(r_cfg.period, r_cfg.dir);

  // RUN sees the counter wrap; ARM never looks at Rc.
  assign w_expire = (r_state == ST_RUN) && bus.Rc;

  // stop beats start beats expiry.
  assign w_clr = bus.start && !bus.stop;
  assign w_inc = w_expire && !bus.start && !bus.stop;

  // Sequencer: state, latched configuration, tick and done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cfg   <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (bus.stop) begin
        r_state <= ST_IDLE;
      end else if (bus.start) begin
        r_state <= ST_LOAD;
        r_cfg   <= '{period: bus.period, dir: bus.dir, mode: bus.mode_auto};
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_LOAD: r_state <= ST_ARM;
          ST_ARM:  r_state <= ST_RUN;
          ST_RUN: begin
            if (w_expire) begin
              r_tick <= 1'b1;
              if (r_cfg.mode) begin
                r_state <= ST_ARM;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Expiries since last start.
  sat_counter #(.W(TICK_W)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (w_inc),
    .o_cnt (w_tick_cnt)
  );

  // Counter is held in load while idle so it always has a defined value;
  // auto-reload reloads on the same edge that consumes the wrap.
  assign bus.Load = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                    (w_expire && r_cfg.mode && !bus.stop);
  assign bus.PData    = w_reload;
  assign bus.s        = r_cfg.dir;
  assign bus.remain   = r_cfg.dir ? ~bus.cnt : bus.cnt;
  assign bus.tick     = r_tick;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.tick_cnt = w_tick_cnt;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with a behavioural counter attached and a reference
// model that predicts every output from the edge count since the last start.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int unsigned     TW  = 2;
  localparam longint unsigned SAT = (64'd1 << TW) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_ctrl_if #(.TICK_W(TW)) tif();

  timer_ctrl #(.TICK_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  // Behavioural 32-bit loadable up/down counter; Rc is frozen while loading.
  always @(posedge clk) begin
    if (tif.Load) begin
      tif.cnt <= tif.PData;
    end else if (tif.s) begin
      tif.cnt <= tif.cnt + 32'd1;
      tif.Rc  <= (tif.cnt == 32'hFFFF_FFFF);
    end else begin
      tif.cnt <= tif.cnt - 32'd1;
      tif.Rc  <= (tif.cnt == 32'd0);
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: k = edges since the start edge. Expiry edges are
  // k = m*(N+2)+1 for m >= 1; ARM when (k-1) is a multiple of N+2.
  bit              m_act;
  longint unsigned m_k;
  longint unsigned m_n;
  bit              m_dir;
  bit              m_auto;
  bit              m_done;
  bit              m_tick;
  longint unsigned m_ticks;

  task automatic model_reset();
    m_act = 0; m_k = 0; m_n = 0; m_dir = 0; m_auto = 0;
    m_done = 0; m_tick = 0; m_ticks = 0;
  endtask

  task automatic model_edge(input bit rs, input bit st, input bit sp,
                            input logic [31:0] per, input bit d, input bit md);
    m_tick = 0;
    if (rs) begin
      model_reset();
    end else if (sp) begin
      m_act = 0;
    end else if (st) begin
      m_act = 1; m_k = 0; m_n = 64'(per); m_dir = d; m_auto = md;
      m_done = 0; m_ticks = 0;
    end else if (m_act) begin
      m_k = m_k + 1;
      if (m_k >= m_n + 3 && ((m_k - 1) % (m_n + 2)) == 0) begin
        m_tick  = 1;
        m_ticks = (m_ticks < SAT) ? m_ticks + 1 : SAT;
        if (!m_auto) begin
          m_done = 1;
          m_act  = 0;
        end
      end
    end
  endtask

  function automatic longint unsigned phase();
    return (m_k - 1) % (m_n + 2);
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_act)    return 2'd0;
    if (m_k == 0)  return 2'd1;
    return (phase() == 0) ? 2'd2 : 2'd3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: combinational checks mid-cycle, then registered checks after the edge.
  task automatic cyc();
    bit          st, sp, rs, d, md, ld;
    logic [31:0] per;
    logic [31:0] pd;
    #1;
    pd = m_dir ? ~m_n[31:0] : m_n[31:0];
    ld = !m_act || (m_k == 0) ||
         ((phase() == m_n + 1) && m_auto && !tif.stop);
    chk("Load",  64'(tif.Load),  64'(ld));
    chk("PData", 64'(tif.PData), 64'(pd));
    chk("s",     64'(tif.s),     64'(m_dir));
    if (m_act && m_k >= 1)
      chk("remain", 64'(tif.remain), 64'(32'(m_n - phase())));
    st = tif.start; sp = tif.stop; rs = rst;
    per = tif.period; d = tif.dir; md = tif.mode_auto;
    @(posedge clk);
    #1;
    model_edge(rs, st, sp, per, d, md);
    chk("state",    64'(tif.state),    64'(exp_state()));
    chk("busy",     64'(tif.busy),     64'(m_act));
    chk("tick",     64'(tif.tick),     64'(m_tick));
    chk("done",     64'(tif.done),     64'(m_done));
    chk("tick_cnt", 64'(tif.tick_cnt), m_ticks);
  endtask

  task automatic go(input bit st, input bit sp, input logic [31:0] per,
                    input bit d, input bit md);
    tif.start = st; tif.stop = sp; tif.period = per; tif.dir = d; tif.mode_auto = md;
    cyc();
    tif.start = 1'b0; tif.stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    tif.start = 1'b0; tif.stop = 1'b0; tif.period = 32'd0;
    tif.dir = 1'b0; tif.mode_auto = 1'b0;
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    chk("rst_cnt", 64'(tif.cnt), 64'd0);
    rst = 1'b0;
    idle(1);

    // One-shot down, N=3: tick after E6, then idle with done.
    go(1, 0, 32'd3, 0, 0);
    idle(8);
    chk("os_done", 64'(tif.done), 64'd1);
    chk("os_cnt",  64'(tif.tick_cnt), 64'd1);

    // Stale Rc from the previous expiry must not fire early: N=5.
    go(1, 0, 32'd5, 0, 0);
    idle(10);

    // Up, N=3, auto-reload: ticks every 5 cycles, saturating at 3.
    go(1, 0, 32'd3, 1, 1);
    chk("up_pdata", 64'(tif.PData), 64'hFFFF_FFFC);
    idle(18);
    go(0, 1, 32'd0, 0, 0);

    // Stop on the very edge that would expire: no tick, count kept at 1.
    go(1, 0, 32'd2, 0, 1);
    idle(8);
    chk("rc_pending", 64'(tif.Rc), 64'd1);
    go(0, 1, 32'd0, 0, 0);
    chk("stop_cnt", 64'(tif.tick_cnt), 64'd1);

    // start and stop together: stop wins.
    go(1, 0, 32'd4, 1, 1);
    idle(2);
    go(1, 1, 32'd1, 0, 0);
    idle(2);

    // Saturation: N=0 auto ticks every 2 cycles; restart clears.
    go(1, 0, 32'd0, 0, 1);
    idle(10);
    go(1, 0, 32'd0, 1, 1);
    idle(3);
    go(0, 1, 32'd0, 0, 0);

    // Largest period, up: reload value 0, no expiry in view.
    go(1, 0, 32'hFFFF_FFFF, 1, 0);
    idle(6);
    go(0, 1, 32'd0, 0, 0);

    // Reset mid-run: immediate IDLE, counter reloads 0 next edge.
    go(1, 0, 32'd4, 1, 1);
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_state", 64'(tif.state), 64'd0);
    chk("arst_tick",  64'(tif.tick),  64'd0);
    chk("arst_done",  64'(tif.done),  64'd0);
    chk("arst_tcnt",  64'(tif.tick_cnt), 64'd0);
    chk("arst_load",  64'(tif.Load),  64'd1);
    chk("arst_pdata", 64'(tif.PData), 64'd0);
    chk("arst_s",     64'(tif.s),     64'd0);
    cyc();
    chk("arst_cnt", 64'(tif.cnt), 64'd0);
    rst = 1'b0;
    idle(1);

    // Randomized commands against the model.
    for (int i = 0; i < 400; i++) begin
      go(($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0),
         32'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable interval-timer sequencer that sits directly upstream of the 32-bit loadable up/down counter in the FSM datapath. It drives the counter's `Load`, `PData` and `s` inputs, and watches its `cnt` and `Rc` outputs. From start/stop commands it produces one-shot or auto-reload expiry ticks, and it masks the counter's stale `Rc` after every load. The counter has no reset of its own; this block gives it a defined value by holding it in load whenever idle or in reset.

## Interface
- `TICK_W`, default 16: width of the saturating expiry counter.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle command; latches `period`, `dir`, `mode_auto` and (re)starts the timer.
- `stop`  in  1  one-cycle command; aborts the timer, returns to IDLE.
- `period`  in  32  terminal distance N; sampled only on `start`.
- `dir`  in  1  1 = count up, 0 = count down.
- `mode_auto`  in  1  1 = auto-reload, 0 = one-shot.
- `Load`  out  1  to counter `Load`.
- `PData`  out  32  to counter `PData`.
- `s`  out  1  to counter `s`.
- `cnt`  in  32  from counter `cnt`.
- `Rc`  in  1  from counter `Rc`, registered by the counter.
- `tick`  out  1  one-cycle expiry pulse, registered.
- `done`  out  1  sticky one-shot completion flag.
- `busy`  out  1  state != IDLE.
- `tick_cnt`  out  TICK_W  expiries since last `start`, saturating.
- `remain`  out  32  `dir_q ? ~cnt : cnt`; valid in ARM/RUN only.
- `state`  out  2  IDLE=0, LOAD=1, ARM=2, RUN=3.

## Operation
- Latched registers: `period_q`, `dir_q`, `mode_q`. All three are captured on accepted `start`.
- Reload value: R = `dir_q ? ~period_q : period_q`. In both directions the counter reaches its wrap in N+1 counts.
- `PData` = R in every state. `s` = `dir_q` in every state.
- `Load` is combinational:
  - 1 in IDLE and LOAD.
  - 1 in RUN when `Rc`=1 and `mode_q`=1 and `stop`=0.
  - 0 otherwise.
- IDLE:
  - Counter held at R.
  - `start` → LOAD, latch inputs, clear `tick_cnt` and `done`.
- LOAD: unconditional → ARM. The counter loads R on this edge.
- ARM:
  - `Rc` is ignored. It still holds its pre-load value, because the counter does not update `Rc` while loading.
  - → RUN.
- RUN, when `Rc`=1 on the sampled edge:
  - `tick` ← 1 and `tick_cnt` increments (saturating).
  - If `mode_q`=1: the counter reloads on the same edge, → ARM.
  - Else: `done` ← 1, → IDLE.
- Priority in every state: `rst` > `stop` > `start` > `Rc`.
  - `stop` → IDLE, no tick, `done` unchanged.
  - `start` while busy restarts: → LOAD, re-latch, clear `tick_cnt` and `done`.
  - `start` and `stop` in the same cycle: `stop` wins.
- `tick_cnt` saturates at all-ones and never wraps.

## Timing
- Reset values:
  - `state`=IDLE, `period_q`=0, `dir_q`=0, `mode_q`=0.
  - `tick`=0, `done`=0, `tick_cnt`=0.
  - Hence during and after reset `Load`=1, `PData`=0, `s`=0, `busy`=0.
- Reset mid-run: immediate IDLE. No tick is issued. The counter reloads 0 on every clock.
- Let E0 be the edge that samples `start`:
  - First `tick` is high in the cycle after edge E0+N+3 (N=0 → E0+3).
  - `done` rises on the same edge as `tick`.
- Auto-reload tick interval = N+2 cycles. The expiry/reload cycle is included.
- `tick` is exactly one cycle wide. `busy` changes on the same edge as `state`.
- `period`=0xFFFFFFFF: R = 0xFFFFFFFF (down) or 0 (up). Expiry comes after 2^32+2 edges. No special-casing.

## Structure
- Shared package or header, also used by the counter's integration wrapper:
  - state encodings IDLE/LOAD/ARM/RUN;
  - `TICK_W` default;
  - the reload-value rule (direction-dependent complement).
- One sub-module: `sat_counter`. It is TICK_W wide, with inputs `clr` and `inc`, and holds at all-ones. It implements `tick_cnt`.
- The counter itself is instantiated beside this block at the next level, not inside it.

## Test plan
- Reset check: assert `rst` mid-stream → `state`=0, `tick`=0, `done`=0, `tick_cnt`=0, `Load`=1, `PData`=0, `s`=0. With the counter model attached, `cnt`=0 one edge after `rst` rises.
- One-shot down, N=3: `start` at E0 → `PData`=3; `cnt` 3,2,1,0,FFFFFFFF at E1–E5; `tick`=1 after E6; `done`=1; `busy`=0; `tick_cnt`=1.
- Up, N=3, auto: `PData`=0xFFFFFFFC; ticks after E6, E11, E16; `tick_cnt`=3 after the third tick.
- Stale `Rc`: after a one-shot expiry (`Rc` held 1), `start` with N=5 → no tick before E8; tick after E8.
- `stop` in the same cycle as RUN sees `Rc`=1 → no tick, IDLE, `tick_cnt` unchanged. Separately, `start` and `stop` together → IDLE.
- Saturation with TICK_W=2, N=0, auto: ticks every 2 cycles. `tick_cnt` goes 1,2,3,3. Re-`start` clears it to 0.
